mc_dispatch_ctrl: RTL
=====================

Name: mc_dispatch_ctrl

Overview:
- Batch scheduler for the Monte-Carlo option-pricing datapath.
- Takes a stream of simulated path end-values and deals them round-robin to CORE_NUM pricing cores, honouring each core's ready signal.
- Collects per-path payoffs from all cores and averages them over a fixed batch.
- Emits one averaged price per batch.
- Sits between the path generator and the MC core array; replaces free-running counter-based distribution with an explicit handshaked batch controller.

Parameters:
- CORE_NUM, 4, number of pricing cores served; power of two, 2..8.
- DW, 12, width of path, strike and price words (unsigned).
- BATCH_LOG2, 8, log2 of paths per batch (default 256 paths).

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a batch when idle.
- K  in  DW  strike price; sampled on accepted start.
- path_valid  in  1  path sample offered.
- path  in  DW  path end-value.
- path_ready  out  1  controller accepts path this cycle.
- core_path_valid  out  CORE_NUM  one-hot dispatch strobe per core.
- core_path  out  DW  path word to the strobed core (shared bus).
- core_K  out  DW  latched strike to all cores.
- core_ready  in  CORE_NUM  core i can take a path.
- core_res_valid  in  CORE_NUM  core i presents a payoff.
- core_res_price  in  CORE_NUM*DW  payoffs; core i at bits [i*DW +: DW].
- price  out  DW  batch-average price; held until next result.
- price_valid  out  1  one-cycle pulse with new price.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (rst=1 at clk edge) forces all state to zero: FSM to IDLE, ptr, counters and accumulator to 0, core_K 0, every output 0. Reset mid-batch abandons the batch; no price_valid follows.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1: latch K into core_K, clear counters and accumulator, ptr=0, go to RUN.
  - start is ignored in every other state.
- RUN, dispatch:
  - path_ready = core_ready[ptr] && (sent < 2^BATCH_LOG2). Combinational from registers and core_ready only, not from path_valid.
  - Transfer when path_valid && path_ready.
  - Cycle after a transfer: core_path = path, core_path_valid[ptr_old] = 1 for exactly one cycle; all other strobe bits 0.
  - Same edge: ptr = (ptr+1) mod CORE_NUM, sent increments.
  - A not-ready core stalls the stream; ptr never skips a core, so dispatch order is strictly 0,1,..,CORE_NUM-1,0,...
- Collection (RUN and DRAIN):
  - Every cycle, add the sum of all core_res_price words whose core_res_valid bit is set to the accumulator.
  - recv increases by popcount(core_res_valid). Simultaneous results from several cores are all taken the same cycle.
  - Accumulator width DW+BATCH_LOG2; no overflow is possible.
  - Results arriving in IDLE or DONE are discarded.
- Transitions:
  - RUN goes to DRAIN on the edge where sent reaches 2^BATCH_LOG2.
  - DRAIN goes to DONE on the edge where recv reaches 2^BATCH_LOG2.
  - If recv reaches the total while sent also completes on the same edge, go straight to DONE.
  - The recv check uses the updated count, so the final result is included.
- DONE (one cycle):
  - price = accumulator >> BATCH_LOG2 (truncate, no rounding).
  - price_valid = 1 for this one cycle.
  - Next state IDLE; price holds its value until the next DONE.
- Latency: price_valid asserts exactly 1 cycle after the edge that accepts the final result.
- Counters sent and recv are BATCH_LOG2+1 bits wide.

Test Plan:
- Reset then idle: rst high 3 cycles, then path_valid=1 with no start -> path_ready=0, all outputs 0, busy=0.
- Basic batch, BATCH_LOG2=2, CORE_NUM=4, all cores ready, K=100, paths 10,20,30,40:
  - Strobes are 0001,0010,0100,1000 on consecutive cycles, core_K=100.
  - Model cores return payoffs 5,6,7,8 -> price=6 (26>>2), single price_valid pulse, then IDLE.
- Backpressure: core_ready[1]=0 for 5 cycles mid-batch -> path_ready=0 those cycles, no strobe, next path goes to core 1, order unbroken.
- Simultaneous results: all 4 cores assert core_res_valid in one cycle with 4095 each -> accumulator +16380, recv +4, price=4095.
- Abort and stray inputs:
  - Reset asserted in DRAIN -> IDLE, no price_valid, price=0.
  - Result pulses in IDLE are ignored by the next batch.
  - start during RUN has no effect.
- Full default batch: 256 paths with random stalls, reference model sum >> 8 -> bit-exact price match; every path dispatched exactly once, in round-robin order.

Source files
------------

// File: rtl/mc_dispatch_ctrl.sv
// Monte-Carlo batch scheduler: deals path samples round-robin to CORE_NUM pricing
// cores and averages their payoffs over 2^BATCH_LOG2 paths into one price.
module mc_dispatch_ctrl #(
  parameter int CORE_NUM   = 4,
  parameter int DW         = 12,
  parameter int BATCH_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          K,
  input  logic                   path_valid,
  input  logic [DW-1:0]          path,
  output logic                   path_ready,
  output logic [CORE_NUM-1:0]    core_path_valid,
  output logic [DW-1:0]          core_path,
  output logic [DW-1:0]          core_K,
  input  logic [CORE_NUM-1:0]    core_ready,
  input  logic [CORE_NUM-1:0]    core_res_valid,
  input  logic [CORE_NUM*DW-1:0] core_res_price,
  output logic [DW-1:0]          price,
  output logic                   price_valid,
  output logic                   busy
);
  localparam int PW    = $clog2(CORE_NUM);
  localparam int CNT_W = BATCH_LOG2 + 1;
  localparam int ACC_W = DW + BATCH_LOG2;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(1) << BATCH_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    ptr;
  logic [CNT_W-1:0] sent, recv, sent_nxt, recv_nxt, res_cnt;
  logic [ACC_W-1:0] acc, acc_nxt, res_sum;
  logic             xfer, collect;

  function automatic logic [DW-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:BATCH_LOG2];
  endfunction

  assign xfer    = path_valid && path_ready;
  assign collect = (state == RUN) || (state == DRAIN);

  // Several cores may report in the same cycle; all of them are summed at once.
  always_comb begin
    res_sum = '0;
    res_cnt = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (core_res_valid[i]) begin
        res_sum = res_sum + ACC_W'(core_res_price[i*DW +: DW]);
        res_cnt = res_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sent_nxt = sent + CNT_W'(xfer);
    recv_nxt = collect ? recv + res_cnt : recv;
    acc_nxt  = collect ? acc + res_sum : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion tests use the post-edge counts so the last result is included.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (sent_nxt == TOTAL) state_nxt = (recv_nxt == TOTAL) ? DONE : DRAIN;
      DRAIN:   if (recv_nxt == TOTAL) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    path_ready  = (state == RUN) && core_ready[ptr] && (sent < TOTAL);
    busy        = collect;
    price_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      sent            <= '0;
      recv            <= '0;
      acc             <= '0;
      core_path_valid <= '0;
      core_path       <= '0;
      core_K          <= '0;
      price           <= '0;
    end else begin
      core_path_valid <= '0;
      if (state == IDLE && start) begin
        core_K <= K;
        ptr    <= '0;
        sent   <= '0;
        recv   <= '0;
        acc    <= '0;
      end else begin
        sent <= sent_nxt;
        recv <= recv_nxt;
        acc  <= acc_nxt;
      end
      // Dispatch stage: strobe the core the pointer named at the accepting edge.
      if (xfer) begin
        core_path_valid <= CORE_NUM'(1) << ptr;
        core_path       <= path;
        ptr             <= ptr + PW'(1);
      end
      if (state_nxt == DONE) price <= avg_trunc(acc_nxt);
    end
  end

endmodule
